// File: rtl/cam_i2c_pkg.sv
// Shared definitions for the camera I2C write sequencer.
// Holds the FSM state enum, master command encodings, command-group length
// and the per-transaction step indices.
package cam_i2c_pkg;

    localparam int unsigned GROUP_LEN = 3;   // reg addr, data hi, data lo
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned STEP_W    = 3;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_STOP  = 2'd2;

    localparam logic [STEP_W-1:0] STEP_START = 3'd0;
    localparam logic [STEP_W-1:0] STEP_ADDR  = 3'd1;
    localparam logic [STEP_W-1:0] STEP_D0    = 3'd2;
    localparam logic [STEP_W-1:0] STEP_D1    = 3'd3;
    localparam logic [STEP_W-1:0] STEP_D2    = 3'd4;
    localparam logic [STEP_W-1:0] STEP_STOP  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FAIL  = 3'd5
    } state_e;

    // Master command issued for a given transaction step.
    function automatic logic [1:0] step_cmd(input logic [STEP_W-1:0] step);
        logic [1:0] cmd;
        case (step)
            STEP_START: cmd = CMD_START;
            STEP_STOP:  cmd = CMD_STOP;
            default:    cmd = CMD_WRITE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/cam_i2c_byte_gather.sv
// FETCH-side packer: collects three consecutive table bytes into one group.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   capture_en_i      a byte is consumed this cycle
//   byte_i            byte to capture
//   bytes_o           captured group, bytes_o[0] = register address
//   idx_o             slot the next captured byte lands in
//   group_valid_o     combinational strobe: this capture completes the group
module cam_i2c_byte_gather
    import cam_i2c_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       capture_en_i,
    input  logic [7:0]                 byte_i,
    output logic [GROUP_LEN-1:0][7:0]  bytes_o,
    output logic [IDX_W-1:0]           idx_o,
    output logic                       group_valid_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_LEN - 1);

    logic [GROUP_LEN-1:0][7:0] bytes_q;
    logic [IDX_W-1:0]          idx_q;

    // Partial groups are held when the producer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bytes_q <= '0;
            idx_q   <= '0;
        end else if (capture_en_i) begin
            for (int unsigned i = 0; i < GROUP_LEN; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    bytes_q[i] <= byte_i;
                end
            end
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign bytes_o       = bytes_q;
    assign idx_o         = idx_q;
    assign group_valid_o = capture_en_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/cam_i2c_write_sequencer.sv
// Camera register write sequencer: turns 3-byte table commands into
// START / addr+W / 3 bytes / STOP on the shared byte-level I2C master,
// with ACK checking, optional NACK retry and sticky error reporting.
// Build option: CAM_I2C_RETRY_EN enables up to MAX_RETRY re-attempts after
// a NACK; without it the first NACK aborts the command.
// Ports:
//   sysClk, rst                         clock, synchronous active-high reset
//   cam_i2c_output_valid/cam_i2c_byte   table byte stream
//   ready_for_next_byte                 combinational byte-consumed pulse
//   cam_id / bus_sel                    target camera, latched per command
//   m_cmd/m_byte/m_cmd_valid/m_ready    command handshake to the I2C master
//   m_done/m_ack                        completion and ACK from the master
//   busy, wr_done, error, wr_count      status to main control
module cam_i2c_write_sequencer
    import cam_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h5D,
    parameter logic [1:0] MAX_RETRY = 2'd3
) (
    input  logic       sysClk,
    input  logic       rst,
    input  logic       cam_i2c_output_valid,
    input  logic [7:0] cam_i2c_byte,
    input  logic       cam_id,
    output logic       ready_for_next_byte,
    output logic [1:0] m_cmd,
    output logic [7:0] m_byte,
    output logic       m_cmd_valid,
    input  logic       m_ready,
    input  logic       m_done,
    input  logic       m_ack,
    output logic       bus_sel,
    output logic       busy,
    output logic       wr_done,
    output logic       error,
    output logic [7:0] wr_count
);

    state_e                    state_q, state_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic                      ack_q, ack_d;
    logic                      abort_q, abort_d;
    logic [1:0]                m_cmd_q, m_cmd_d;
    logic [7:0]                m_byte_q, m_byte_d;
    logic                      m_cmd_valid_q, m_cmd_valid_d;
    logic                      bus_sel_q, bus_sel_d;
    logic                      busy_q, busy_d;
    logic                      wr_done_q, wr_done_d;
    logic                      error_q, error_d;
    logic [7:0]                wr_count_q, wr_count_d;
    logic                      load_cmd_c;
    logic                      capture_en_c;
    logic [GROUP_LEN-1:0][7:0] grp;
    logic [IDX_W-1:0]          grp_idx;
    logic                      group_valid;

`ifdef CAM_I2C_RETRY_EN
    logic [1:0]                retry_q, retry_d;
`else
    logic                      unused_max_retry_c;
    assign unused_max_retry_c = ^MAX_RETRY;
`endif

    // Byte presented for a WRITE step; START/STOP carry no byte.
    function automatic logic [7:0] step_byte(input logic [STEP_W-1:0]         step,
                                             input logic [GROUP_LEN-1:0][7:0] g);
        logic [7:0] b;
        case (step)
            STEP_ADDR: b = {DEV_ADDR, 1'b0};
            STEP_D0:   b = g[0];
            STEP_D1:   b = g[1];
            STEP_D2:   b = g[2];
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

    assign capture_en_c        = (state_q == ST_FETCH) && cam_i2c_output_valid;
    assign ready_for_next_byte = ((state_q == ST_FETCH) || (state_q == ST_FAIL))
                                 && cam_i2c_output_valid;

    cam_i2c_byte_gather u_gather (
        .clk_i         (sysClk),
        .rst_i         (rst),
        .capture_en_i  (capture_en_c),
        .byte_i        (cam_i2c_byte),
        .bytes_o       (grp),
        .idx_o         (grp_idx),
        .group_valid_o (group_valid)
    );

    // State and registered outputs.
    always_ff @(posedge sysClk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            ack_q         <= 1'b0;
            abort_q       <= 1'b0;
            m_cmd_q       <= 2'd0;
            m_byte_q      <= 8'h00;
            m_cmd_valid_q <= 1'b0;
            bus_sel_q     <= 1'b0;
            busy_q        <= 1'b0;
            wr_done_q     <= 1'b0;
            error_q       <= 1'b0;
            wr_count_q    <= 8'h00;
`ifdef CAM_I2C_RETRY_EN
            retry_q       <= 2'd0;
`endif
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            ack_q         <= ack_d;
            abort_q       <= abort_d;
            m_cmd_q       <= m_cmd_d;
            m_byte_q      <= m_byte_d;
            m_cmd_valid_q <= m_cmd_valid_d;
            bus_sel_q     <= bus_sel_d;
            busy_q        <= busy_d;
            wr_done_q     <= wr_done_d;
            error_q       <= error_d;
            wr_count_q    <= wr_count_d;
`ifdef CAM_I2C_RETRY_EN
            retry_q       <= retry_d;
`endif
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        ack_d         = ack_q;
        abort_d       = abort_q;
        m_cmd_d       = m_cmd_q;
        m_byte_d      = m_byte_q;
        m_cmd_valid_d = m_cmd_valid_q;
        bus_sel_d     = bus_sel_q;
        wr_done_d     = 1'b0;
        error_d       = error_q;
        wr_count_d    = wr_count_q;
        load_cmd_c    = 1'b0;
`ifdef CAM_I2C_RETRY_EN
        retry_d       = retry_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cam_i2c_output_valid) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // First byte of a new command clears a previous failure.
                if (capture_en_c && (grp_idx == '0)) begin
                    error_d = 1'b0;
                end
                if (group_valid) begin
                    bus_sel_d  = cam_id;
                    step_d     = STEP_START;
                    abort_d    = 1'b0;
`ifdef CAM_I2C_RETRY_EN
                    retry_d    = 2'd0;
`endif
                    load_cmd_c = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_cmd_valid_q && m_ready) begin
                    m_cmd_valid_d = 1'b0;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_done) begin
                    ack_d   = m_ack;
                    state_d = ST_NEXT;
                    // Completion is reported as soon as the STOP finishes.
                    if ((step_q == STEP_STOP) && !abort_q) begin
                        wr_done_d  = 1'b1;
                        wr_count_d = wr_count_q + 8'd1;
                    end
                end
            end
            ST_NEXT: begin
                if (step_q == STEP_STOP) begin
                    if (abort_q) begin
                        state_d = ST_FAIL;
                    end else if (cam_i2c_output_valid) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if ((step_q != STEP_START) && !ack_q) begin
`ifdef CAM_I2C_RETRY_EN
                    if (retry_q < MAX_RETRY) begin
                        // Repeated START, no STOP between attempts.
                        retry_d = retry_q + 2'd1;
                        step_d  = STEP_START;
                    end else begin
                        error_d = 1'b1;
                        abort_d = 1'b1;
                        step_d  = STEP_STOP;
                    end
`else
                    error_d = 1'b1;
                    abort_d = 1'b1;
                    step_d  = STEP_STOP;
`endif
                    load_cmd_c = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    step_d     = step_q + STEP_W'(1);
                    load_cmd_c = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_FAIL: begin
                // Drain the rest of the stream until the table goes quiet.
                if (!cam_i2c_output_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_cmd_c) begin
            m_cmd_d       = step_cmd(step_d);
            m_byte_d      = step_byte(step_d, grp);
            m_cmd_valid_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign m_cmd       = m_cmd_q;
    assign m_byte      = m_byte_q;
    assign m_cmd_valid = m_cmd_valid_q;
    assign bus_sel     = bus_sel_q;
    assign busy        = busy_q;
    assign wr_done     = wr_done_q;
    assign error       = error_q;
    assign wr_count    = wr_count_q;

endmodule
